// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - streams a contiguous range of memory words out over a valid/ready port
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   start             command strobe, sampled only while idle
//   start_addr        first word address, captured with start
//   word_count        number of words to read (0..2^ADDR_WIDTH), captured with start
//   busy, done        transfer in progress / one-cycle completion pulse
//   mem_rd_en         read request to the memory's synchronous read port
//   mem_addr          read address (valid with mem_rd_en)
//   mem_rdata         read data, returned one cycle after mem_rd_en
//   out_valid/ready   stream handshake
//   out_data          stream word
//   out_addr          address the word was read from
//   out_last          final word of the transfer
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH     = (CW+1)'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  done_r;

    // Request issued last cycle; its data is on mem_rdata this cycle.
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  pop;
    logic                  issue;
    logic [CW:0]           occupancy;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // Slots that will be committed after this edge. Counting the in-flight
    // word up front means the FIFO can never overflow, and crediting the pop
    // lets issue resume in the same cycle a stalled consumer frees a slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue     = (state == S_READ) && (occupancy < DEPTH);

    assign mem_rd_en = issue;
    assign mem_addr  = addr;
    assign busy      = (state != S_IDLE);
    assign done      = done_r;
    assign out_data  = fifo_data[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            done_r        <= 1'b0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_last <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            inflight      <= issue;
            inflight_addr <= addr;
            inflight_last <= (remaining == (ADDR_WIDTH+1)'(1));
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr      <= start_addr;
                            remaining <= word_count;
                            state     <= S_READ;
                        end else begin
                            done_r    <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr      <= addr + 1'b1;  // wraps modulo 2^ADDR_WIDTH
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_addr[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            if (inflight && !pop) begin
                count <= count + 1'b1;
            end else if (!inflight && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] img [0:4095];
    int            cyc   = 0;
    int            n_vec = 0;
    int            n_bad = 0;

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   wc;
        logic [3:0]    pat;        // out_ready in cycle rel is pat[rel % 4]
        bit            inj;        // extra start pulse at cycle 2
        int            exp_first;  // -1: not checked
        int            exp_done;   // -1: not checked
    } vec_t;

    vec_t vt [7];
    vec_t vr;

    mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= img[mem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_busy"},      busy,      0);
        chk({p, "_done"},      done,      0);
        chk({p, "_mem_rd_en"}, mem_rd_en, 0);
        chk({p, "_mem_addr"},  mem_addr,  0);
        chk({p, "_out_valid"}, out_valid, 0);
        chk({p, "_out_data"},  out_data,  0);
        chk({p, "_out_addr"},  out_addr,  0);
        chk({p, "_out_last"},  out_last,  0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int            rel, base, nrx, done_rel, first_rel, reads, mon, fifo_m, inflight_m;
        logic          pop, pv_stall, p_last;
        logic [DW-1:0] p_data;
        logic [AW-1:0] p_addr, ea;
        string         tag;
        tag = $sformatf("v%0d", idx);
        nrx = 0; done_rel = -1; first_rel = -1; reads = 0; mon = 0;
        fifo_m = 0; inflight_m = 0; pv_stall = 1'b0;
        p_data = '0; p_addr = '0; p_last = 1'b0;

        @(negedge clk);
        start = 1'b1; start_addr = v.sa; word_count = v.wc; out_ready = v.pat[0];
        @(negedge clk);
        start = 1'b0;
        base = cyc - 1;
        for (int k = 0; k < 200 && done_rel < 0; k++) begin
            if (k > 0) @(negedge clk);
            rel = cyc - base;
            if (v.inj) begin
                start = (rel == 2);
                if (rel == 2) begin
                    start_addr = 12'd7;
                    word_count = 13'd5;
                end
            end
            out_ready = v.pat[rel % 4];
            #1;
            pop = out_valid && out_ready;
            if (out_valid && first_rel < 0) first_rel = rel;
            if (mem_rd_en && (fifo_m + inflight_m - int'(pop)) >= 2) mon++;
            if (pv_stall && (out_data !== p_data || out_addr !== p_addr || out_last !== p_last)) mon++;
            if (done && out_valid) mon++;
            if (done) begin
                done_rel = rel;
                if (busy) mon++;
            end else if (!busy) begin
                mon++;
            end
            if (mem_rd_en) reads++;
            if (pop) begin
                ea = v.sa + AW'(nrx);
                chk($sformatf("%s_data%0d", tag, nrx), out_data, img[ea]);
                chk($sformatf("%s_addr%0d", tag, nrx), out_addr, ea);
                chk($sformatf("%s_last%0d", tag, nrx), out_last, (nrx == int'(v.wc) - 1));
                nrx++;
            end
            fifo_m     = fifo_m + inflight_m - int'(pop);
            inflight_m = int'(mem_rd_en);
            pv_stall   = out_valid && !out_ready;
            p_data = out_data; p_addr = out_addr; p_last = out_last;
        end
        start = 1'b0;

        chk({tag, "_done_seen"},  (done_rel >= 0), 1);
        chk({tag, "_word_count"}, nrx,   int'(v.wc));
        chk({tag, "_read_count"}, reads, int'(v.wc));
        chk({tag, "_monitors"},   mon,   0);
        if (v.exp_first >= 0) chk({tag, "_first_valid"}, first_rel, v.exp_first);
        if (v.exp_done >= 0)  chk({tag, "_done_cycle"},  done_rel,  v.exp_done);

        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        int found;
        for (int i = 0; i < 4096; i++) img[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        img[2048] = 32'h11; img[2049] = 32'h22; img[2050] = 32'h33; img[2051] = 32'h44;

        vt[0] = '{12'd2048, 13'd4,  4'b1111, 1'b0, 3,  7};
        vt[1] = '{12'd2048, 13'd4,  4'b1001, 1'b0, 3,  9};
        vt[2] = '{12'd4094, 13'd4,  4'b1111, 1'b0, 3,  7};
        vt[3] = '{12'd0,    13'd0,  4'b1111, 1'b0, -1, 1};
        vt[4] = '{12'd100,  13'd1,  4'b1111, 1'b0, 3,  4};
        vt[5] = '{12'd4000, 13'd10, 4'b0110, 1'b0, 3, -1};
        vt[6] = '{12'd2048, 13'd4,  4'b1111, 1'b1, 3,  7};

        reset = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Reset two cycles after the first out_valid of a running transfer.
        @(negedge clk);
        out_ready = 1'b1; start = 1'b1; start_addr = 12'd2048; word_count = 13'd8;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (out_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_first_valid", found, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        #1;
        chk_reset_outputs("mid_rst_hold");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_release_valid", out_valid, 0);
        chk("rst_release_busy",  busy,      0);
        vr = '{12'd300, 13'd3, 4'b1111, 1'b0, 3, 6};
        run_vec(vr, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Hardware read-out engine for the CPU's word-addressed unified memory. It is the reading counterpart of the bench-side image load, which writes `.text` at word 0 and `.data` at word 2048. On a start command it streams a contiguous range of memory words out over a valid/ready interface, so self-checking benches and debug logic can capture memory contents after execution. It sits beside the CPU on a dedicated synchronous read port of the memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: word-address width (4096 words; `.data` base = 2048).
- `DATA_WIDTH`, 32: memory word width.
- `FIFO_DEPTH`, 2: output buffer entries. Must be ≥2 for full throughput.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only when `busy`=0.
- `start_addr`  in  ADDR_WIDTH  first word address, captured with `start`.
- `word_count`  in  ADDR_WIDTH+1  number of words to read (0..2^ADDR_WIDTH), captured with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at completion.
- `mem_rd_en`  out  1  read request to memory.
- `mem_addr`  out  ADDR_WIDTH  read address. Valid when `mem_rd_en`=1.
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly one cycle after `mem_rd_en`.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_addr`  out  ADDR_WIDTH  address the word was read from.
- `out_last`  out  1  marks the final word of the transfer.

## Operation
- States: IDLE, READ (issuing requests), DRAIN (all requests issued; FIFO/in-flight not yet empty).
- IDLE with `start`=1 and `word_count`>0: capture address and count, go to READ, `busy`←1.
- IDLE with `start`=1 and `word_count`=0: stay in IDLE. `done` pulses the next cycle. No reads, no output.
- `start` is ignored while `busy`=1.
- Issue rule: in READ, assert `mem_rd_en` when (fifo_count + inflight − pop) < FIFO_DEPTH, where pop = `out_valid`&`out_ready`. After each issue, the address increments and the remaining count decrements. The last issue moves the FSM to DRAIN.
- The address wraps modulo 2^ADDR_WIDTH (4095 → 0). `out_addr` reflects the wrapped value.
- The word returned one cycle after issue is pushed into the FIFO together with its address and a last flag (remaining count was 1 at issue). No overflow is possible by construction.
- The FIFO head drives `out_data`, `out_addr`, and `out_last`. Stream outputs are stable while `out_valid`=1 and `out_ready`=0.
- Accepting the word with `out_last`=1 moves the FSM to IDLE. `busy`←0 and `done`←1 for one cycle.
- Reset asserted at any time: FSM→IDLE. FIFO and counters are cleared. An in-flight read is discarded, and its `mem_rdata` the following cycle is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0.
- If `start` is sampled at edge E0, `busy`=1 and the first `mem_rd_en` are high in the cycle after E0. `mem_rdata` returns one cycle later and is written into the FIFO at the next edge, so `out_valid` first rises 3 cycles after E0 (E0+3).
- With `out_ready` held at 1, the block delivers one word per cycle. An N-word transfer finishes its last handshake at E0+N+2, and `done` is high in the following cycle.
- Backpressure: with `out_ready`=0, at most FIFO_DEPTH words are buffered plus 0 in flight. Issue resumes in the same cycle as the pop.
- `busy` is high from E0+1 through the cycle of the last handshake. It is low in the cycle where `done`=1.
- `done` and `out_valid` never overlap.

## Test plan
- Load mem[2048..2051] = 0x11,0x22,0x33,0x44. Set `start_addr`=2048, `word_count`=4, `out_ready`=1 → 4 words on consecutive cycles, first at E0+3, with `out_addr` 2048..2051 and `out_last` only on 0x44. `done` pulses at E0+7.
- Same transfer with `out_ready` toggling 1,0,0,1,… → word order unchanged and no drops or duplicates. While stalled, `mem_rd_en` is never high with the FIFO full and nothing popping.
- `start_addr`=4094, `word_count`=4 → `out_addr` sequence 4094, 4095, 0, 1.
- `word_count`=0 → no `mem_rd_en`, no `out_valid`, `busy` stays 0, `done` pulses at E0+1.
- Second `start` pulse mid-transfer with different arguments → ignored, and the original stream completes unchanged.
- Assert reset two cycles after the first `out_valid` → all outputs return to reset values immediately. A new `start` after reset release produces a clean stream beginning at the new `start_addr`.
